// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and imem request FSM; presents one instr to decode.
// Optional misalign trap (output misalign, state ERR) under FETCH_MISALIGN_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              pcsrc,
  input  logic              jump,
  input  logic              jumpr,
  input  logic [31:0]       signimm,
  input  logic [31:0]       rs_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcplus4
`ifdef FETCH_MISALIGN_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] br_tgt;
  logic              retire;
  logic              bad_tgt;

  assign pcplus4 = pc + 32'd4;
  assign br_tgt  = pcplus4 + (signimm << 2);
  assign retire  = (state_q == VALID) && !stall;
  assign bad_tgt = |next_pc[1:0];

  // overlapping selects are legal: jumpr > jump > pcsrc
  always_comb begin
    next_pc = pcplus4;
    priority case (1'b1)
      jumpr:   next_pc = rs_data;
      jump:    next_pc = {pcplus4[31:28], instr[25:0], 2'b00};
      pcsrc:   next_pc = br_tgt;
      default: next_pc = pcplus4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (imem_ready) state_d = VALID;
      VALID: begin
        if (!stall) begin
`ifdef FETCH_MISALIGN_EN
          state_d = bad_tgt ? ERR : FETCH;
`else
          state_d = FETCH;
`endif
        end
      end
      ERR:   state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == FETCH);
    imem_addr = pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else if (state_q == FETCH && imem_ready) begin
      instr       <= imem_rdata;
      instr_valid <= 1'b1;
    end else if (retire) begin
      instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      pc          <= next_pc;
`else
      // low bits dropped so a bad jr target cannot wedge fetch
      pc          <= next_pc & ~32'h3;
`endif
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                misalign <= 1'b0;
    else if (retire && bad_tgt) misalign <= 1'b1;
  end
`else
  logic unused_bad;
  assign unused_bad = bad_tgt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// Expected fetch addresses are queued at retire, checked at request.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        pcsrc;
  logic        jump;
  logic        jumpr;
  logic [31:0] signimm;
  logic [31:0] rs_data;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcplus4;
`ifdef FETCH_MISALIGN_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .pcsrc      (pcsrc),
    .jump       (jump),
    .jumpr      (jumpr),
    .signimm    (signimm),
    .rs_data    (rs_data),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pcplus4    (pcplus4)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalign   (misalign)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input int lat, input logic [31:0] rdata,
                          input int nstall, input logic ps,
                          input logic j, input logic jr,
                          input logic [31:0] imm,
                          input logic [31:0] rs);
    logic [31:0] a, p4, nxt;
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req", imem_req, 1);
    a = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check("addr", imem_addr, a);
    repeat (lat) begin
      imem_ready = 1'b0;
      tick();
      check("hold_addr", imem_addr, a);
      check("hold_req", imem_req, 1);
      check("hold_nv", instr_valid, 0);
    end
    imem_ready = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check("valid", instr_valid, 1);
    check("instr", instr, rdata);
    check("pc", pc, a);
    check("pcplus4", pcplus4, a + 32'd4);
    check("req_off", imem_req, 0);
    stall = 1'b1;
    repeat (nstall) begin
      tick();
      check("stl_instr", instr, rdata);
      check("stl_pc", pc, a);
      check("stl_valid", instr_valid, 1);
      check("stl_req", imem_req, 0);
    end
    p4 = a + 32'd4;
    if (jr)      nxt = rs;
    else if (j)  nxt = {p4[31:28], rdata[25:0], 2'b00};
    else if (ps) nxt = p4 + (imm << 2);
    else         nxt = p4;
    stall   = 1'b0;
    pcsrc   = ps;
    jump    = j;
    jumpr   = jr;
    signimm = imm;
    rs_data = rs;
    tick();
    pcsrc   = 1'b0;
    jump    = 1'b0;
    jumpr   = 1'b0;
    signimm = $urandom;
    rs_data = $urandom;
    check("retired", instr_valid, 0);
`ifdef FETCH_MISALIGN_EN
    if (nxt[1:0] == 2'b00) sb.push_back(nxt);
`else
    sb.push_back(nxt & ~32'h3);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    stall      = 1'b0;
    pcsrc      = 1'b0;
    jump       = 1'b0;
    jumpr      = 1'b0;
    signimm    = '0;
    rs_data    = '0;
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (3) tick();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_req", imem_req, 0);
    imem_ready = 1'b0;
    reset = 1'b1;
    check("idle_req", imem_req, 0);
    sb.push_back(32'h0);

    // sequential 0,4,8,C
    for (int i = 0; i < 4; i++)
      do_instr(0, $urandom, 0, 0, 0, 0, 0, 0);
    // at 0x10: branch back -2 words -> 0xC
    do_instr(0, $urandom, 0, 1, 0, 0, 32'hFFFF_FFFE, 0);
    do_instr(0, $urandom, 0, 0, 0, 0, 0, 0);
    // at 0x10 again: jump beats pcsrc -> 0x100
    do_instr(0, 32'h0800_0040, 0, 1, 1, 0, 32'h0000_0010, 0);
    // jumpr beats everything -> 0x400
    do_instr(0, 32'h0800_0040, 0, 1, 1, 1, 32'h0000_0010,
             32'h0000_0400);
    // slow memory then long stall
    do_instr(3, $urandom, 4, 0, 0, 0, 0, 0);
    do_instr(0, $urandom, 0, 0, 0, 1, 0, 32'h0000_0020);

    // reset mid-FETCH at 0x20
    begin
      logic [31:0] a;
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
        tick();
        n++;
      end
      a = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      check("mid_addr", imem_addr, a);
      tick();
      reset = 1'b0;
      #1;
      check("mid_pc", pc, 32'h0);
      check("mid_valid", instr_valid, 0);
      check("mid_req", imem_req, 0);
      tick();
      reset = 1'b1;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      check("post_valid", instr_valid, 0);
      check("post_req", imem_req, 1);
      check("post_addr", imem_addr, 32'h0);
      sb.push_back(32'h0);
    end

    // misaligned jr target
    do_instr(0, $urandom, 0, 0, 0, 1, 0, 32'h0000_0403);
`ifdef FETCH_MISALIGN_EN
    repeat (3) begin
      check("err_mis", misalign, 1);
      check("err_req", imem_req, 0);
      check("err_valid", instr_valid, 0);
      tick();
    end
    check("err_pc", pc, 32'h0000_0403);
`else
    do_instr(0, $urandom, 0, 0, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream neighbour of the main controller/datapath. Owns the PC register and drives the instruction-memory request handshake.
- Presents one instruction at a time to decode and holds it while decode stalls.
- Computes the next PC from the decode stage's pcsrc/jump/jumpr decisions when the current instruction retires.
- Decouples the core from variable-latency instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; fixed at 32 for the MIPS datapath.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  decode/execute not ready; holds the current instruction.
- pcsrc  in  1  taken branch (branch & zero) for the current instruction.
- jump  in  1  j/jal for the current instruction.
- jumpr  in  1  jr for the current instruction.
- signimm  in  32  sign-extended immediate of the current instruction.
- rs_data  in  32  register rs value (jr target).
- imem_addr  out  32  instruction fetch address (= pc).
- imem_req  out  1  fetch request.
- imem_ready  in  1  memory returns data this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  instruction presented to decode.
- instr_valid  out  1  instr is valid.
- pc  out  32  address of instr.
- pcplus4  out  32  pc + 4 (link value for jal).

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0.
- States:
  - IDLE: imem_req=0. Next cycle goes to FETCH unconditionally.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready: instr<=imem_rdata, instr_valid<=1, go to VALID. Otherwise stay; address held stable.
  - VALID: instr_valid=1, imem_req=0.
    - stall=1: stay; instr and pc held.
    - stall=0: retire. pc<=next_pc, instr_valid<=0, go to FETCH.
- Minimum instruction period is 2 cycles (FETCH with immediate ready, then VALID). imem_ready is ignored outside FETCH.
- next_pc priority: jumpr > jump > pcsrc > sequential.
  - jumpr: rs_data.
  - jump: {pcplus4[31:28], instr[25:0], 2'b00}.
  - pcsrc: pcplus4 + (signimm<<2).
  - sequential: pcplus4.
- Control inputs are sampled only in VALID with stall=0.
- Arithmetic is modulo 2^32: pc=32'hFFFF_FFFC sequential wraps to 0; branch targets wrap silently.
- No branch delay slot; the redirected address is the very next fetch.
- Simultaneous jump and pcsrc: jump wins. jumpr with any other: jumpr wins.
- Reset mid-FETCH: the request is abandoned and a late imem_ready is ignored. After reset release the fetch restarts from RESET_PC via IDLE.
- stall held indefinitely in VALID: outputs stable, no imem traffic.

Optional Feature:
- Macro FETCH_MISALIGN_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0) and state ERR.
  - If a retire computes next_pc[1:0]!=0 (only reachable via jumpr), pc still updates, misalign<=1, and state goes to ERR.
  - ERR: imem_req=0, instr_valid=0, sticky until reset.
- Undefined:
  - No misalign port.
  - next_pc[1:0] is forced to 2'b00 before loading pc; fetch continues.

Test Plan:
- Reset, then imem_ready=1 every cycle, stall=0, no redirects -> imem_addr sequence 0,4,8,C; instr_valid high every 2nd cycle; pcplus4 = pc+4.
- At pc=32'h10, pcsrc=1, signimm=32'hFFFF_FFFE -> next fetch address 32'h0C; the second case checks priority and must be built from this same pc=32'h10: jump=1 with pcsrc=1, instr[25:0]=26'h40 -> next fetch address 32'h100.
- jumpr=1, rs_data=32'h0000_0400, with jump=1 and pcsrc=1 also asserted -> next fetch address 32'h400.
- imem_ready delayed 3 cycles, then stall=1 for 4 cycles in VALID -> imem_addr stable through the wait; instr and pc held; no new imem_req until stall drops.
- Assert reset low mid-FETCH at pc=32'h20, then release, then pulse imem_ready -> pc=RESET_PC, instr_valid=0; one IDLE cycle; first fetch address RESET_PC.
- jumpr to 32'h0000_0403 -> FETCH_MISALIGN_EN defined: misalign=1, imem_req stays 0. Undefined: next fetch address 32'h400.
